uart_word_loader: RTL and testbench

Parametrised successor to the fixed 4-byte UART instruction loader in the wrapper. It assembles received UART bytes into words of configurable width and byte order, and writes them sequentially into instruction memory. Loading stops on an end-of-program word, when memory is full, or on abort. It adds an inter-byte timeout and break recovery. It sits between the UART receiver and the instruction memory write port; write_done releases the core from reset.

---
 rtl/uart_word_loader_pkg.sv | 26 ++
 rtl/uart_word_loader_timeout_ctr.sv | 44 ++++
 rtl/uart_word_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_word_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_loader_pkg.sv
// Shared definitions for the UART word loader.
// Contents: loader state encodings and enum, default end-of-program word,
// byte-index to lane mapping helper.
package uart_loader_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COLLECT = ST_COLLECT,
      DONE    = ST_DONE
   } state_e;

   // Terminator default: all ones; the top slices it to its word width.
   localparam logic [63:0] END_WORD_DFLT = '1;

   // Lane (byte position inside the word) that receives byte number idx.
   function automatic int unsigned lane_of(input int unsigned idx,
                                           input int unsigned nbytes,
                                           input bit          big_endian);
      return big_endian ? (nbytes - 1 - idx) : idx;
   endfunction

endpackage

// File: rtl/uart_word_loader_timeout_ctr.sv
// Inter-byte idle counter for the UART word loader.
// Ports: clk, resetn (sync, active low), clear (restart count), run (count
// enable), expire_c (combinational pulse on the TIMEOUT_CYC-th counted cycle).
// TIMEOUT_CYC = 0 removes the counter and ties expire_c low.
module loader_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic run,
   output logic expire_c
);

   if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, resetn, clear, run};
      assign expire_c      = 1'b0;
   end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Fires on the cycle that would bring the count to TIMEOUT_CYC.
      always_comb begin
         expire_c = run && !clear && (cnt_q == CW'(TIMEOUT_CYC - 1));
         cnt_d    = cnt_q;
         if (clear || expire_c) begin
            cnt_d = '0;
         end else if (run) begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!resetn) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

endmodule

// File: rtl/uart_word_loader.sv
// UART word loader: packs received bytes into WORD_BYTES-wide words and writes
// them sequentially into instruction memory until an END_WORD terminator,
// memory full, or abort (load_en low). Partial words are dropped on inter-byte
// timeout or UART break.
// Ports: clk, resetn (sync, active low), load_en, rx_valid/rx_data/rx_break
// from the receiver; mem_we/mem_addr/mem_wdata to memory; write_done, busy,
// word_count, err_timeout, err_break status.
// Optional: define UART_WORD_LOADER_CHECKSUM_EN to add a checksum output
// (running XOR of every written word in the session).
module uart_word_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned WORD_BYTES  = 4,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned BIG_ENDIAN  = 0,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter logic [8*WORD_BYTES-1:0] END_WORD = END_WORD_DFLT[8*WORD_BYTES-1:0]
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    load_en,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   input  logic                    rx_break,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*WORD_BYTES-1:0] mem_wdata,
   output logic                    write_done,
   output logic                    busy,
   output logic [ADDR_W:0]         word_count,
   output logic                    err_timeout,
   output logic                    err_break
`ifdef UART_WORD_LOADER_CHECKSUM_EN
   ,
   output logic [8*WORD_BYTES-1:0] checksum
`endif
);

   localparam int unsigned DW    = 8 * WORD_BYTES;
   localparam int unsigned CW    = ADDR_W + 1;
   localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DW-1:0]     asm_q, asm_d;
   logic [DW-1:0]     word_c;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic              write_done_q, write_done_d;
   logic              busy_q, busy_d;
   logic [CW-1:0]     word_count_q, word_count_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_break_q, err_break_d;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
   logic [DW-1:0]     checksum_q, checksum_d;
`endif
   int unsigned       lane_c;
   logic              run_c;
   logic              expire_c;

   // Idle clocks only matter while a word is partly assembled.
   assign run_c = (state_q == COLLECT) && (idx_q != '0);

   loader_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (rx_valid | rx_break | ~run_c),
      .run      (run_c),
      .expire_c (expire_c)
   );

   // Assembly register with the incoming byte merged into its lane.
   always_comb begin
      lane_c = lane_of(32'(idx_q), WORD_BYTES, BIG_ENDIAN != 0);
      word_c = asm_q;
      for (int unsigned l = 0; l < WORD_BYTES; l++) begin
         if (l == lane_c) begin
            word_c[8*l +: 8] = rx_data;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      asm_d         = asm_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      word_count_d  = word_count_q;
      err_timeout_d = err_timeout_q;
      err_break_d   = err_break_q;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      checksum_d    = checksum_q;
`endif

      // Address moves on the edge after a write; pinned at the last slot.
      if (mem_we_q && (mem_addr_q != LAST_ADDR)) begin
         mem_addr_d = mem_addr_q + ADDR_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (load_en) begin
               state_d       = COLLECT;
               idx_d         = '0;
               asm_d         = '0;
               mem_addr_d    = '0;
               word_count_d  = '0;
               err_timeout_d = 1'b0;
               err_break_d   = 1'b0;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
               checksum_d    = '0;
`endif
            end
         end
         COLLECT: begin
            if (!load_en) begin
               state_d = IDLE;
               idx_d   = '0;
               asm_d   = '0;
            end else if (rx_break) begin
               idx_d       = '0;
               asm_d       = '0;
               err_break_d = 1'b1;
            end else if (rx_valid) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  asm_d = '0;
                  if (word_c == END_WORD) begin
                     state_d = DONE;
                  end else begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = word_c;
                     if (word_count_q != DEPTH_CNT) begin
                        word_count_d = word_count_q + CW'(1);
                     end
`ifdef UART_WORD_LOADER_CHECKSUM_EN
                     checksum_d = checksum_q ^ word_c;
`endif
                     if (mem_addr_d == LAST_ADDR) begin
                        state_d = DONE;
                     end
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  asm_d = word_c;
               end
            end else if (expire_c) begin
               idx_d         = '0;
               asm_d         = '0;
               err_timeout_d = 1'b1;
            end
         end
         DONE: begin
            if (!load_en) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d       = (state_d == COLLECT);
      write_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         asm_q         <= '0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         write_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         word_count_q  <= '0;
         err_timeout_q <= 1'b0;
         err_break_q   <= 1'b0;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
         checksum_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         asm_q         <= asm_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         write_done_q  <= write_done_d;
         busy_q        <= busy_d;
         word_count_q  <= word_count_d;
         err_timeout_q <= err_timeout_d;
         err_break_q   <= err_break_d;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
         checksum_q    <= checksum_d;
`endif
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign write_done  = write_done_q;
   assign busy        = busy_q;
   assign word_count  = word_count_q;
   assign err_timeout = err_timeout_q;
   assign err_break   = err_break_q;
`ifdef UART_WORD_LOADER_CHECKSUM_EN
   assign checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: a little-endian and a big-endian instance share
// one directed byte stream; a byte-queue model predicts every output each
// cycle and literal checks pin key values.
`timescale 1ns/1ps
module tb_uart_word_loader;

   localparam int unsigned WB = 4;
   localparam int unsigned AW = 2;
   localparam int unsigned DEP = 4;
   localparam int unsigned TO = 20;

   logic clk = 1'b0;
   logic resetn, load_en, rx_valid, rx_break;
   logic [7:0] rx_data;

   logic          mem_we      [2];
   logic [AW-1:0] mem_addr    [2];
   logic [31:0]   mem_wdata   [2];
   logic          write_done  [2];
   logic          busy        [2];
   logic [AW:0]   word_count  [2];
   logic          err_timeout [2];
   logic          err_break   [2];
`ifdef UART_WORD_LOADER_CHECKSUM_EN
   logic [31:0]   checksum    [2];
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   uart_word_loader #(.WORD_BYTES(WB), .ADDR_W(AW), .DEPTH(DEP), .BIG_ENDIAN(0), .TIMEOUT_CYC(TO)) u_le (
      .clk(clk), .resetn(resetn), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_break(rx_break), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .write_done(write_done[0]), .busy(busy[0]), .word_count(word_count[0]),
      .err_timeout(err_timeout[0]), .err_break(err_break[0])
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      , .checksum(checksum[0])
`endif
   );

   uart_word_loader #(.WORD_BYTES(WB), .ADDR_W(AW), .DEPTH(DEP), .BIG_ENDIAN(1), .TIMEOUT_CYC(TO)) u_be (
      .clk(clk), .resetn(resetn), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_break(rx_break), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .write_done(write_done[1]), .busy(busy[1]), .word_count(word_count[1]),
      .err_timeout(err_timeout[1]), .err_break(err_break[1])
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      , .checksum(checksum[1])
`endif
   );

   // Model state: 0 idle, 1 collecting, 2 done.
   bit          started = 1'b0;
   int          m_state [2];
   int          m_nb    [2];
   logic [7:0]  m_bytes [2][WB];
   int          m_idle  [2];
   int          m_cnt   [2];
   int          m_addr  [2];
   bit          m_et    [2];
   bit          m_eb    [2];
   bit          m_we    [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_csum  [2];

   // Captured from the DUT writes for the literal checks.
   int          n_wr      [2];
   int          last_addr [2];
   logic [31:0] last_data [2];

   always @(posedge clk) begin : model
      bit          prev_we;
      logic [31:0] w;
      if (!resetn) started = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!resetn) begin
            m_state[k] = 0; m_nb[k] = 0; m_idle[k] = 0; m_cnt[k] = 0; m_addr[k] = 0;
            m_et[k] = 0; m_eb[k] = 0; m_we[k] = 0; m_wdata[k] = '0; m_csum[k] = '0;
         end else begin
            prev_we = m_we[k];
            m_we[k] = 1'b0;
            if (prev_we && m_addr[k] != int'(DEP) - 1) m_addr[k]++;
            case (m_state[k])
               0: if (load_en) begin
                  m_state[k] = 1; m_nb[k] = 0; m_idle[k] = 0; m_cnt[k] = 0;
                  m_addr[k] = 0; m_et[k] = 0; m_eb[k] = 0; m_csum[k] = '0;
               end
               1: begin
                  if (!load_en) begin
                     m_state[k] = 0; m_nb[k] = 0; m_idle[k] = 0;
                  end else if (rx_break) begin
                     m_nb[k] = 0; m_idle[k] = 0; m_eb[k] = 1;
                  end else if (rx_valid) begin
                     m_bytes[k][m_nb[k]] = rx_data;
                     m_nb[k]++;
                     m_idle[k] = 0;
                     if (m_nb[k] == int'(WB)) begin
                        m_nb[k] = 0;
                        w = '0;
                        for (int i = 0; i < int'(WB); i++)
                           w[8*((k == 1) ? (int'(WB) - 1 - i) : i) +: 8] = m_bytes[k][i];
                        if (w == 32'hffff_ffff) begin
                           m_state[k] = 2;
                        end else begin
                           m_we[k] = 1'b1;
                           m_wdata[k] = w;
                           m_cnt[k]++;
                           m_csum[k] = m_csum[k] ^ w;
                           if (m_cnt[k] == int'(DEP)) m_state[k] = 2;
                        end
                     end
                  end else if (m_nb[k] != 0) begin
                     m_idle[k]++;
                     if (m_idle[k] == int'(TO)) begin
                        m_nb[k] = 0; m_idle[k] = 0; m_et[k] = 1;
                     end
                  end
               end
               default: if (!load_en) m_state[k] = 0;
            endcase
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin : cmp
      bit ok;
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            ok = (mem_we[k] === m_we[k]) && (mem_addr[k] === AW'(m_addr[k]))
               && (!m_we[k] || mem_wdata[k] === m_wdata[k])
               && (write_done[k] === (m_state[k] == 2)) && (busy[k] === (m_state[k] == 1))
               && (word_count[k] === 3'(m_cnt[k]))
               && (err_timeout[k] === m_et[k]) && (err_break[k] === m_eb[k]);
`ifdef UART_WORD_LOADER_CHECKSUM_EN
            ok = ok && (checksum[k] === m_csum[k]);
`endif
            n_total++;
            if (!ok) begin
               n_bad++;
               $display("FAIL cycle inst%0d t=%0t: got we=%b addr=%0d wd=%h done=%b busy=%b cnt=%0d et=%b eb=%b, want we=%b addr=%0d wd=%h done=%b busy=%b cnt=%0d et=%b eb=%b",
                        k, $time, mem_we[k], mem_addr[k], mem_wdata[k], write_done[k], busy[k],
                        word_count[k], err_timeout[k], err_break[k], m_we[k], m_addr[k], m_wdata[k],
                        m_state[k] == 2, m_state[k] == 1, m_cnt[k], m_et[k], m_eb[k]);
            end
            if (mem_we[k] === 1'b1) begin
               n_wr[k]++;
               last_addr[k] = int'(mem_addr[k]);
               last_data[k] = mem_wdata[k];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      send(b0); send(b1); send(b2); send(b3);
   endtask

   task automatic session(input logic en);
      load_en = en;
      tick(1);
   endtask

   int wr0;

   initial begin
      n_wr = '{0, 0};
      last_addr = '{0, 0};
      last_data = '{32'h0, 32'h0};
      resetn = 1'b0; load_en = 1'b0; rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
      tick(2);
      resetn = 1'b1;
      chk("reset_we", 64'(mem_we[0]), 64'd0);
      chk("reset_addr", 64'(mem_addr[0]), 64'd0);
      chk("reset_wdata", 64'(mem_wdata[1]), 64'd0);
      chk("reset_count", 64'(word_count[0]), 64'd0);

      // Basic words, both byte orders, then terminator.
      session(1'b1);
      chk("busy_on_entry", 64'(busy[0]), 64'd1);
      send_word(8'h13, 8'h01, 8'h01, 8'hfc);
      tick(2);
      chk("le_word0", 64'(last_data[0]), 64'hfc010113);
      chk("be_word0", 64'(last_data[1]), 64'h130101fc);
      chk("le_addr0", 64'(last_addr[0]), 64'd0);
      chk("count1", 64'(word_count[0]), 64'd1);
      send_word(8'hfc, 8'h01, 8'h01, 8'h13);
      tick(2);
      chk("be_word1", 64'(last_data[1]), 64'hfc010113);
      chk("be_addr1", 64'(last_addr[1]), 64'd1);
      send_word(8'h01, 8'h02, 8'h03, 8'h04);
      send_word(8'hff, 8'hff, 8'hff, 8'hff);
      tick(2);
      chk("term_writes", 64'(n_wr[0]), 64'd3);
      chk("term_done", 64'(write_done[0]), 64'd1);
      chk("term_busy", 64'(busy[0]), 64'd0);
      chk("term_count", 64'(word_count[1]), 64'd3);
      session(1'b0);
      chk("done_clears", 64'(write_done[0]), 64'd0);

      // Timeout: exact budget discards, one short of it does not.
      session(1'b1);
      send(8'h11); send(8'h22);
      tick(TO);
      chk("timeout_flag", 64'(err_timeout[0]), 64'd1);
      chk("timeout_nowrite", 64'(word_count[0]), 64'd0);
      send_word(8'h21, 8'h43, 8'h65, 8'h87);
      tick(2);
      chk("timeout_recover", 64'(last_data[0]), 64'h87654321);
      chk("timeout_addr0", 64'(last_addr[0]), 64'd0);
      send(8'haa); send(8'hbb);
      tick(TO - 1);
      send(8'hcc); send(8'hdd);
      tick(2);
      chk("gap_below_limit", 64'(last_data[0]), 64'hddccbbaa);

      // Abort mid-word keeps status until the next session.
      send(8'h01); send(8'h02);
      session(1'b0);
      tick(1);
      chk("abort_done", 64'(write_done[0]), 64'd0);
      chk("abort_count_held", 64'(word_count[0]), 64'd2);

      // Break recovery, including break colliding with a byte.
      session(1'b1);
      send(8'h01); send(8'h02);
      rx_break = 1'b1; tick(1); rx_break = 1'b0;
      send_word(8'hde, 8'had, 8'hbe, 8'hef);
      tick(2);
      chk("break_flag", 64'(err_break[0]), 64'd1);
      chk("break_recover", 64'(last_data[0]), 64'hefbeadde);
      send(8'h55);
      rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h77; tick(1);
      rx_break = 1'b0; rx_valid = 1'b0;
      send_word(8'h01, 8'h02, 8'h03, 8'h04);
      tick(2);
      chk("break_drops_byte", 64'(last_data[0]), 64'h04030201);
      chk("break_addr1", 64'(last_addr[0]), 64'd1);
      session(1'b0);

      // Memory full at DEPTH words; fifth word ignored.
      session(1'b1);
      wr0 = n_wr[0];
      for (int i = 0; i < 5; i++)
         send_word(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48));
      tick(3);
      chk("full_writes", 64'(n_wr[0] - wr0), 64'd4);
      chk("full_last_addr", 64'(last_addr[0]), 64'd3);
      chk("full_last_data", 64'(last_data[0]), 64'h33231303);
      chk("full_done", 64'(write_done[0]), 64'd1);
      chk("full_count", 64'(word_count[0]), 64'd4);
      session(1'b0);

      // Reset in the middle of a word.
      session(1'b1);
      send(8'h99); send(8'h98);
      resetn = 1'b0; tick(1); resetn = 1'b1;
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_count", 64'(word_count[1]), 64'd0);
      chk("rst_addr", 64'(mem_addr[0]), 64'd0);
      tick(1);
      send_word(8'h0a, 8'h0b, 8'h0c, 8'h0d);
      tick(2);
      chk("rst_recover", 64'(last_data[0]), 64'h0d0c0b0a);
      chk("rst_recover_addr", 64'(last_addr[0]), 64'd0);
      session(1'b0);

      // Checksum words.
      session(1'b1);
      send_word(8'h0f, 8'h00, 8'h00, 8'h00);
      send_word(8'hf0, 8'h00, 8'h00, 8'h00);
      tick(2);
      chk("cs_word1", 64'(last_data[0]), 64'h000000f0);
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      chk("checksum_le", 64'(checksum[0]), 64'h000000ff);
      chk("checksum_be", 64'(checksum[1]), 64'hff000000);
`endif
      session(1'b0);
      tick(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
